vec_lane_sequencer: RTL

Multi-cycle sequencer that executes vector instructions (VADD, VMOV, VMOVI, VCOMPMOV, VCOMPMOVI) one 16-bit lane per cycle through the shared scalar ALU of the execute stage, instead of four parallel lane adders. It sits beside the execute stage. It latches a vector instruction on a start pulse, requests the ALU lane by lane, and assembles the 64-bit result. It stalls the front end while busy and issues a single vector-register write strobe on completion.

---
 rtl/vec_lane_sequencer_if.sv | 49 ++++
 rtl/vec_lane_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer_if.sv
// Purpose: groups the decode, ALU-lane and vector-writeback signals of the lane sequencer.
// Latency: none (pure signal bundle).
// Backpressure: O_StallSignal holds decode; I_AluGrant gates each lane step.
interface vec_lane_sequencer_if #(
   parameter int LANE_W    = 16,
   parameter int NUM_LANES = 4,
   parameter int VREG_ID_W = 6
);
   localparam int VREG_W = LANE_W * NUM_LANES;
   localparam int CNT_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   // decode side
   logic                 I_Start;
   logic [2:0]           I_VecOp;
   logic [VREG_W-1:0]    I_VecSrc1Value;
   logic [VREG_W-1:0]    I_VecSrc2Value;
   logic [LANE_W-1:0]    I_Src1Value;
   logic [LANE_W-1:0]    I_Imm;
   logic [CNT_W-1:0]     I_Idx;
   logic [VREG_ID_W-1:0] I_DestVRegIdx;
   logic                 I_Flush;
   // shared scalar ALU
   logic                 I_AluGrant;
   logic [LANE_W-1:0]    I_AluResult;
   logic                 O_AluReq;
   logic [LANE_W-1:0]    O_AluA;
   logic [LANE_W-1:0]    O_AluB;
   logic                 O_AluOp;
   // status and writeback
   logic                 O_Busy;
   logic                 O_StallSignal;
   logic                 O_VRegWEn;
   logic [VREG_ID_W-1:0] O_DestVRegIdx;
   logic [VREG_W-1:0]    O_VecDestValue;

   modport master (
      input  I_Start, I_VecOp, I_VecSrc1Value, I_VecSrc2Value, I_Src1Value,
             I_Imm, I_Idx, I_DestVRegIdx, I_Flush, I_AluGrant, I_AluResult,
      output O_AluReq, O_AluA, O_AluB, O_AluOp, O_Busy, O_StallSignal,
             O_VRegWEn, O_DestVRegIdx, O_VecDestValue
   );

   modport slave (
      output I_Start, I_VecOp, I_VecSrc1Value, I_VecSrc2Value, I_Src1Value,
             I_Imm, I_Idx, I_DestVRegIdx, I_Flush, I_AluGrant, I_AluResult,
      input  O_AluReq, O_AluA, O_AluB, O_AluOp, O_Busy, O_StallSignal,
             O_VRegWEn, O_DestVRegIdx, O_VecDestValue
   );
endinterface

// File: rtl/vec_lane_sequencer.sv
// Purpose: runs vector ops one lane per cycle through the shared scalar ALU and assembles the result.
// Latency: full ops strobe 4 edges after start, COMPMOV ops 1 edge; each grant-low RUN cycle adds one.
// Backpressure: stalls decode while busy; a lane only advances on an edge with I_AluGrant high.
module vec_lane_sequencer #(
   parameter int LANE_W    = 16,
   parameter int NUM_LANES = 4,
   parameter int VREG_ID_W = 6
) (
   input  logic                 I_CLOCK,
   input  logic                 I_RESET,
   vec_lane_sequencer_if.master bus
);
   localparam int VREG_W = LANE_W * NUM_LANES;
   localparam int CNT_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   localparam logic [2:0] OP_VADD      = 3'd0;
   localparam logic [2:0] OP_VMOV      = 3'd1;
   localparam logic [2:0] OP_VMOVI     = 3'd2;
   localparam logic [2:0] OP_VCOMPMOV  = 3'd3;
   localparam logic [2:0] OP_VCOMPMOVI = 3'd4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     lane_q;
   logic [2:0]           op_q;
   logic [VREG_W-1:0]    src1_q, src2_q, result_q;
   logic [LANE_W-1:0]    scal_q, imm_q;
   logic [VREG_ID_W-1:0] dest_q;

   logic legal_op, accept, is_comp_q, last_lane, lane_wr;
   int   lane_base;

   assign legal_op  = (bus.I_VecOp <= OP_VCOMPMOVI);
   assign accept    = (state_q == IDLE) & bus.I_Start & legal_op & ~bus.I_Flush;
   assign is_comp_q = (op_q == OP_VCOMPMOV) | (op_q == OP_VCOMPMOVI);
   // COMPMOV touches a single lane, so its only lane is also its last
   assign last_lane = is_comp_q | (lane_q == CNT_W'(NUM_LANES - 1));
   // flush wins over grant: no lane is written on a flushing edge
   assign lane_wr   = (state_q == RUN) & bus.I_AluGrant & ~bus.I_Flush;
   assign lane_base = int'(lane_q) * LANE_W;

   // state register, updated on the pipeline's negative edge
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // next-state: flush beats grant and start; DONE always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            if (bus.I_Flush)                       state_d = IDLE;
            else if (bus.I_AluGrant && last_lane)  state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand latch on accept and lane-by-lane result assembly
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         lane_q   <= '0;
         op_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         scal_q   <= '0;
         imm_q    <= '0;
         dest_q   <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q     <= bus.I_VecOp;
         src1_q   <= bus.I_VecSrc1Value;
         src2_q   <= bus.I_VecSrc2Value;
         scal_q   <= bus.I_Src1Value;
         imm_q    <= bus.I_Imm;
         dest_q   <= bus.I_DestVRegIdx;
         // untouched lanes of COMPMOV keep the current destination contents
         result_q <= bus.I_VecSrc1Value;
         if ((bus.I_VecOp == OP_VCOMPMOV) || (bus.I_VecOp == OP_VCOMPMOVI))
            lane_q <= bus.I_Idx;
         else
            lane_q <= '0;
      end else if (lane_wr) begin
         result_q[lane_base +: LANE_W] <= bus.I_AluResult;
         if (!last_lane) lane_q <= lane_q + 1'b1;
      end
   end

   // ALU operand steering for the current lane; quiet zeros outside RUN
   always_comb begin
      bus.O_AluA  = '0;
      bus.O_AluB  = '0;
      bus.O_AluOp = 1'b0;
      if (state_q == RUN) begin
         case (op_q)
            OP_VADD: begin
               bus.O_AluA  = src1_q[lane_base +: LANE_W];
               bus.O_AluB  = src2_q[lane_base +: LANE_W];
               bus.O_AluOp = 1'b0;
            end
            OP_VMOV: begin
               bus.O_AluA  = src1_q[lane_base +: LANE_W];
               bus.O_AluOp = 1'b1;
            end
            OP_VMOVI, OP_VCOMPMOVI: begin
               bus.O_AluA  = imm_q;
               bus.O_AluOp = 1'b1;
            end
            OP_VCOMPMOV: begin
               bus.O_AluA  = scal_q;
               bus.O_AluOp = 1'b1;
            end
            default: begin
               bus.O_AluA  = '0;
               bus.O_AluOp = 1'b0;
            end
         endcase
      end
   end

   assign bus.O_AluReq       = (state_q == RUN);
   assign bus.O_Busy         = (state_q != IDLE);
   assign bus.O_StallSignal  = (state_q != IDLE) | accept;
   // a flush arriving in DONE cancels the writeback
   assign bus.O_VRegWEn      = (state_q == DONE) & ~bus.I_Flush;
   assign bus.O_DestVRegIdx  = dest_q;
   assign bus.O_VecDestValue = result_q;
endmodule
